// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM reader front end: per-key FSM state
// encoding, default timing constants and state classification helpers.
package rom_reader_pkg;

  typedef enum logic [2:0] {
    KS_WAIT_RELEASE = 3'd0,
    KS_IDLE         = 3'd1,
    KS_DEB_PRESS    = 3'd2,
    KS_HELD_DELAY   = 3'd3,
    KS_HELD_REPEAT  = 3'd4,
    KS_DEB_RELEASE  = 3'd5
  } key_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 50000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5000000;
  localparam int unsigned DEF_COUNTER_WIDTH        = 26;

  // Accepted level is "pressed"; DEB_RELEASE counts because the release
  // has not been accepted yet.
  function automatic logic is_held(input key_state_t s);
    return (s == KS_HELD_DELAY) || (s == KS_HELD_REPEAT) || (s == KS_DEB_RELEASE);
  endfunction

  // Key is released (or waiting to be seen released): the other key may fire.
  function automatic logic is_armed(input key_state_t s);
    return (s == KS_IDLE) || (s == KS_WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button channel: 2-flop synchronizer, debounce/hold FSM and
// saturating timers. Emits a registered one-cycle event per press/repeat.
module key_debouncer
  import rom_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int unsigned COUNTER_WIDTH        = DEF_COUNTER_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic auto_repeat_en,
  output logic event_pulse,
  output logic held,
  output logic armed
);

  localparam logic [COUNTER_WIDTH-1:0] DEB_LIM = COUNTER_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] RD_LIM  = COUNTER_WIDTH'(REPEAT_DELAY_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] RP_LIM  = COUNTER_WIDTH'(REPEAT_PERIOD_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  logic                     sync1, sync2;
  key_state_t               state, state_next;
  key_state_t               ret_state, ret_next;
  logic [COUNTER_WIDTH-1:0] deb_cnt, deb_next, deb_inc;
  logic [COUNTER_WIDTH-1:0] hold_cnt, hold_next, hold_inc;
  logic                     event_next;

  assign deb_inc  = (deb_cnt  == '1) ? deb_cnt  : deb_cnt  + ONE;
  assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + ONE;

  assign held  = is_held(state);
  assign armed = is_armed(state);

  // Synchronizer, FSM state, timers and the event register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state       <= KS_WAIT_RELEASE;
      ret_state   <= KS_HELD_DELAY;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      event_pulse <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      state       <= state_next;
      ret_state   <= ret_next;
      deb_cnt     <= deb_next;
      hold_cnt    <= hold_next;
      event_pulse <= event_next;
    end
  end

  // Next state, timer updates and event generation. The first disagreeing
  // sample is counted on entry to a debounce state, so acceptance lands
  // exactly DEBOUNCE_CYCLES edges after the synchronized level changes.
  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    deb_next   = deb_cnt;
    hold_next  = hold_cnt;
    event_next = 1'b0;
    case (state)
      KS_WAIT_RELEASE: begin
        if (sync2) begin
          if (deb_inc >= DEB_LIM) begin
            state_next = KS_IDLE;
            deb_next   = '0;
          end else begin
            deb_next = deb_inc;
          end
        end else begin
          deb_next = '0;
        end
      end
      KS_IDLE: begin
        if (!sync2) begin
          state_next = KS_DEB_PRESS;
          deb_next   = ONE;
        end
      end
      KS_DEB_PRESS: begin
        if (!sync2) begin
          if (deb_inc >= DEB_LIM) begin
            state_next = KS_HELD_DELAY;
            deb_next   = '0;
            hold_next  = '0;
            event_next = 1'b1;
          end else begin
            deb_next = deb_inc;
          end
        end else begin
          state_next = KS_IDLE;
          deb_next   = '0;
        end
      end
      KS_HELD_DELAY, KS_HELD_REPEAT: begin
        if (sync2) begin
          state_next = KS_DEB_RELEASE;
          ret_next   = state;
          deb_next   = ONE;
        end else if (auto_repeat_en &&
                     (hold_inc >= ((state == KS_HELD_DELAY) ? RD_LIM : RP_LIM))) begin
          state_next = KS_HELD_REPEAT;
          hold_next  = '0;
          event_next = 1'b1;
        end else begin
          hold_next = hold_inc;
        end
      end
      KS_DEB_RELEASE: begin
        // Hold timer is frozen here so a release bounce resumes the schedule.
        if (sync2) begin
          if (deb_inc >= DEB_LIM) begin
            state_next = KS_IDLE;
            deb_next   = '0;
            hold_next  = '0;
          end else begin
            deb_next = deb_inc;
          end
        end else begin
          state_next = ret_state;
          deb_next   = '0;
        end
      end
      default: begin
        state_next = KS_WAIT_RELEASE;
        deb_next   = '0;
        hold_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_event_conditioner.sv
// Two debounced key channels with arbitration into mutually exclusive
// registered increment/decrement pulses and a conflict flag.
module key_event_conditioner
  import rom_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter int unsigned COUNTER_WIDTH        = DEF_COUNTER_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_inc_n,
  input  logic key_dec_n,
  input  logic auto_repeat_en,
  output logic increment_address,
  output logic decrement_address,
  output logic key_conflict
);

  logic inc_event, inc_held, inc_armed;
  logic dec_event, dec_held, dec_armed;

  key_debouncer #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
    .COUNTER_WIDTH        (COUNTER_WIDTH)
  ) u_inc (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_n          (key_inc_n),
    .auto_repeat_en (auto_repeat_en),
    .event_pulse    (inc_event),
    .held           (inc_held),
    .armed          (inc_armed)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
    .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
    .COUNTER_WIDTH        (COUNTER_WIDTH)
  ) u_dec (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_n          (key_dec_n),
    .auto_repeat_en (auto_repeat_en),
    .event_pulse    (dec_event),
    .held           (dec_held),
    .armed          (dec_armed)
  );

  // Output register: an event passes only while the other key is released.
  // A firing channel is already out of IDLE, so both never pass together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      increment_address <= 1'b0;
      decrement_address <= 1'b0;
      key_conflict      <= 1'b0;
    end else begin
      increment_address <= inc_event & dec_armed;
      decrement_address <= dec_event & inc_armed;
      key_conflict      <= inc_held & dec_held;
    end
  end

endmodule

// File: tb/tb_key_event_conditioner.sv
// Directed bench for key_event_conditioner with short timing parameters.
// Inputs change and outputs are sampled on the falling edge; iteration i
// drives the level seen by rising edge i and checks outputs after it.
module tb_key_event_conditioner;

  logic clk = 1'b0;
  logic reset_n;
  logic key_inc_n;
  logic key_dec_n;
  logic auto_repeat_en;
  logic increment_address;
  logic decrement_address;
  logic key_conflict;

  int errors = 0;
  int checks = 0;

  key_event_conditioner #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (5),
    .COUNTER_WIDTH        (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_inc_n         (key_inc_n),
    .key_dec_n         (key_dec_n),
    .auto_repeat_en    (auto_repeat_en),
    .increment_address (increment_address),
    .decrement_address (decrement_address),
    .key_conflict      (key_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_inc_n = 1'b1; key_dec_n = 1'b1; auto_repeat_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({increment_address, decrement_address, key_conflict} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b%b%b exp=000", i,
                 increment_address, decrement_address, key_conflict);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({increment_address, decrement_address, key_conflict} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d got=%b%b%b exp=000", i,
                 increment_address, decrement_address, key_conflict);
      end
    end
  endtask

  task automatic test_clean_press();
    int npulse = 0;
    auto_repeat_en = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      key_inc_n = (i <= 10) ? 1'b0 : 1'b1;
      tick();
      if (increment_address) npulse++;
      checks++;
      if (increment_address !== (i == 7)) begin
        errors++;
        $display("FAIL clean_inc cyc=%0d got=%b exp=%b", i, increment_address, (i == 7));
      end
      checks++;
      if ((decrement_address !== 1'b0) || (key_conflict !== 1'b0)) begin
        errors++;
        $display("FAIL clean_dec_conf cyc=%0d got=%b%b exp=00", i,
                 decrement_address, key_conflict);
      end
    end
    checks++;
    if (npulse !== 1) begin
      errors++;
      $display("FAIL clean_pulse_count got=%0d exp=1", npulse);
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    auto_repeat_en = 1'b0;
    for (int i = 1; i <= 44; i++) begin
      if (i <= 20)      key_dec_n = (((i - 1) / 2) % 2 == 1);
      else if (i <= 26) key_dec_n = 1'b1;
      else if (i <= 34) key_dec_n = 1'b0;
      else              key_dec_n = 1'b1;
      tick();
      if (decrement_address) npulse++;
      checks++;
      if (decrement_address !== (i == 33)) begin
        errors++;
        $display("FAIL bounce_dec cyc=%0d got=%b exp=%b", i, decrement_address, (i == 33));
      end
      checks++;
      if ((increment_address !== 1'b0) || (key_conflict !== 1'b0)) begin
        errors++;
        $display("FAIL bounce_inc_conf cyc=%0d got=%b%b exp=00", i,
                 increment_address, key_conflict);
      end
    end
    checks++;
    if (npulse !== 1) begin
      errors++;
      $display("FAIL bounce_pulse_count got=%0d exp=1", npulse);
    end
  endtask

  task automatic test_auto_repeat();
    logic exp;
    auto_repeat_en = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      key_inc_n = (i <= 60) ? 1'b0 : 1'b1;
      tick();
      exp = (i == 7) || ((i >= 27) && (i <= 62) && (((i - 27) % 5) == 0));
      checks++;
      if (increment_address !== exp) begin
        errors++;
        $display("FAIL repeat_inc cyc=%0d got=%b exp=%b", i, increment_address, exp);
      end
      checks++;
      if (decrement_address !== 1'b0) begin
        errors++;
        $display("FAIL repeat_dec cyc=%0d got=%b exp=0", i, decrement_address);
      end
    end
    auto_repeat_en = 1'b0;
  endtask

  task automatic test_conflict();
    logic exp_inc, exp_conf;
    auto_repeat_en = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      key_inc_n = (i <= 60) ? 1'b0 : 1'b1;
      key_dec_n = ((i >= 11) && (i <= 42)) ? 1'b0 : 1'b1;
      tick();
      exp_inc  = (i == 7) || (i == 52) || (i == 57) || (i == 62);
      exp_conf = (i >= 17) && (i <= 48);
      checks++;
      if (increment_address !== exp_inc) begin
        errors++;
        $display("FAIL conflict_inc cyc=%0d got=%b exp=%b", i, increment_address, exp_inc);
      end
      checks++;
      if (decrement_address !== 1'b0) begin
        errors++;
        $display("FAIL conflict_dec cyc=%0d got=%b exp=0", i, decrement_address);
      end
      checks++;
      if (key_conflict !== exp_conf) begin
        errors++;
        $display("FAIL conflict_flag cyc=%0d got=%b exp=%b", i, key_conflict, exp_conf);
      end
    end
    auto_repeat_en = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    logic exp_inc;
    auto_repeat_en = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      key_inc_n = ((i <= 50) || ((i >= 57) && (i <= 70))) ? 1'b0 : 1'b1;
      reset_n   = ((i >= 30) && (i <= 32)) ? 1'b0 : 1'b1;
      tick();
      exp_inc = (i == 7) || (i == 27) || (i == 63);
      checks++;
      if (increment_address !== exp_inc) begin
        errors++;
        $display("FAIL rst_mid_inc cyc=%0d got=%b exp=%b", i, increment_address, exp_inc);
      end
      checks++;
      if ((decrement_address !== 1'b0) || (key_conflict !== 1'b0)) begin
        errors++;
        $display("FAIL rst_mid_dec_conf cyc=%0d got=%b%b exp=00", i,
                 decrement_address, key_conflict);
      end
    end
    auto_repeat_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; key_inc_n = 1'b1; key_dec_n = 1'b1; auto_repeat_en = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_conflict();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
